// File: rtl/dadda_err_monitor.sv
// Error-statistics monitor for an approximate 8x8 multiplier: accepts (A,B,P) samples,
// accumulates count/error-count/sum|ed|/max|ed|. Optional signed sum via DADDA_ERR_MON_SIGNED_ED_EN.
module dadda_err_monitor #(
  parameter int unsigned N_SAMPLES = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [15:0] P,
  output logic [31:0] sample_count,
  output logic [31:0] err_count,
  output logic [39:0] sum_ed_abs,
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
  output logic [39:0] sum_ed,
`endif
  output logic [15:0] max_ed,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [31:0] NCNT = 32'(N_SAMPLES);

  state_e      state_q, state_d;
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic        take;
  logic        accept;

  logic        v1_q;
  logic [7:0]  a1_q, b1_q;
  logic [15:0] p1_q;
  logic        v2_q;
  logic [15:0] ed2_q;
  logic [15:0] exact;
  logic [15:0] ed_d;

  logic [31:0] cnt_q, err_q;
  logic [39:0] sum_q;
  logic [15:0] max_q;

`ifdef DADDA_ERR_MON_SIGNED_ED_EN
  logic [16:0] diff_d, diff2_q;
  logic [39:0] sed_q;
`endif

  always_comb begin
    take     = start && (state_q != S_RUN);
    in_ready = (state_q == S_RUN) && (acc_cnt_q < NCNT);
    accept   = in_valid && in_ready;

    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      // Stage-1 empty with the quota reached means the last sample accumulates on
      // this edge, so done rises together with the final counter values.
      S_RUN:   if ((acc_cnt_q == NCNT) && !v1_q) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    acc_cnt_d = acc_cnt_q;
    if (take)        acc_cnt_d = '0;
    else if (accept) acc_cnt_d = acc_cnt_q + 32'd1;
  end

  always_comb begin
    exact = 16'(a1_q) * 16'(b1_q);
    ed_d  = (exact >= p1_q) ? (exact - p1_q) : (p1_q - exact);
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
    diff_d = {1'b0, exact} - {1'b0, p1_q};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      p1_q  <= '0;
      v2_q  <= 1'b0;
      ed2_q <= '0;
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
      diff2_q <= '0;
`endif
    end else begin
      v1_q <= accept;
      if (accept) begin
        a1_q <= A;
        b1_q <= B;
        p1_q <= P;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        ed2_q <= ed_d;
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
        diff2_q <= diff_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
      sed_q <= '0;
`endif
    end else if (take) begin
      cnt_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
      sed_q <= '0;
`endif
    end else if (v2_q) begin
      cnt_q <= cnt_q + 32'd1;
      if (ed2_q != '0) err_q <= err_q + 32'd1;
      sum_q <= sum_q + 40'(ed2_q);
      if (ed2_q > max_q) max_q <= ed2_q;
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
      sed_q <= sed_q + {{23{diff2_q[16]}}, diff2_q};
`endif
    end
  end

  assign sample_count = cnt_q;
  assign err_count    = err_q;
  assign sum_ed_abs   = sum_q;
  assign max_ed       = max_q;
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
  assign sum_ed       = sed_q;
`endif
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_dadda_err_monitor.sv
// Bench for dadda_err_monitor: directed scenarios on a 4-sample instance and a
// 10000-sample randomized run on a default instance against an arithmetic model.
module tb_dadda_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s_start, s_valid, s_ready, s_busy, s_done;
  logic [7:0]  s_a, s_b;
  logic [15:0] s_p, s_max;
  logic [31:0] s_cnt, s_err;
  logic [39:0] s_sum;

  logic        b_start, b_valid, b_ready, b_busy, b_done;
  logic [7:0]  b_a, b_b;
  logic [15:0] b_p, b_max;
  logic [31:0] b_cnt, b_err;
  logic [39:0] b_sum;

`ifdef DADDA_ERR_MON_SIGNED_ED_EN
  logic [39:0] s_sed, b_sed;
`endif

  dadda_err_monitor #(.N_SAMPLES(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .A(s_a), .B(s_b), .P(s_p), .sample_count(s_cnt), .err_count(s_err), .sum_ed_abs(s_sum),
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
    .sum_ed(s_sed),
`endif
    .max_ed(s_max), .busy(s_busy), .done(s_done)
  );

  dadda_err_monitor #(.N_SAMPLES(10000)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .A(b_a), .B(b_b), .P(b_p), .sample_count(b_cnt), .err_count(b_err), .sum_ed_abs(b_sum),
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
    .sum_ed(b_sed),
`endif
    .max_ed(b_max), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic s_expect(input string tag, input longint cnt, input longint err,
                          input longint sum, input longint mx);
    chk({tag, ".sample_count"}, s_cnt, cnt);
    chk({tag, ".err_count"},    s_err, err);
    chk({tag, ".sum_ed_abs"},   s_sum, sum);
    chk({tag, ".max_ed"},       s_max, mx);
  endtask

  int          acc;
  int          cyc;
  int          ready_gaps;
  longint      m_cnt, m_err, m_sum, m_max, m_sed;
  logic [15:0] ex16;
  logic [39:0] sed40;
  int          d;

  initial begin
    rst_n = 1'b0;
    s_start = 0; s_valid = 0; s_a = '0; s_b = '0; s_p = '0;
    b_start = 0; b_valid = 0; b_a = '0; b_b = '0; b_p = '0;
    repeat (3) tick;
    s_expect("reset", 0, 0, 0, 0);
    chk("reset.in_ready", s_ready, 0);
    chk("reset.busy", s_busy, 0);
    chk("reset.done", s_done, 0);
    rst_n = 1'b1;
    tick;
    chk("idle.busy", s_busy, 0);
    chk("idle.in_ready", s_ready, 0);

    // single exact sample, 2-edge latency
    s_start = 1; tick; s_start = 0;
    chk("run.busy", s_busy, 1);
    chk("run.in_ready", s_ready, 1);
    s_valid = 1; s_a = 10; s_b = 20; s_p = 200; tick;
    s_valid = 0; tick;
    chk("latency1.sample_count", s_cnt, 0);
    tick;
    s_expect("one", 1, 0, 0, 0);

    // two erroneous samples back to back
    s_valid = 1; s_a = 255; s_b = 255; s_p = 16'd65000; tick;
    s_a = 3; s_b = 5; s_p = 12; tick;
    s_valid = 0; tick; tick;
    s_expect("pair", 3, 2, 28, 25);
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
    chk("pair.sum_ed", s_sed, 40'd28);
`endif

    // fourth sample: P above exact, fills the quota
    s_valid = 1; s_a = 2; s_b = 3; s_p = 10; tick;
    s_valid = 0;
    chk("full.in_ready", s_ready, 0);
    tick;
    chk("pre_done.done", s_done, 0);
    tick;
    s_expect("full", 4, 3, 32, 25);
    chk("full.done", s_done, 1);
    chk("full.busy", s_busy, 0);
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
    sed40 = 40'd24;
    chk("full.sum_ed", s_sed, sed40);
`endif

    s_valid = 1; repeat (3) tick; s_valid = 0;
    s_expect("hold", 4, 3, 32, 25);
    chk("hold.done", s_done, 1);

    // restart from DONE, then burst of 6 valid cycles
    s_start = 1; tick; s_start = 0;
    s_expect("restart", 0, 0, 0, 0);
    chk("restart.busy", s_busy, 1);
    chk("restart.done", s_done, 0);
    s_a = 7; s_b = 9; s_p = 63; s_valid = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (s_ready) acc++;
      tick;
    end
    s_valid = 0;
    chk("burst.accepted", acc, 4);
    chk("burst.in_ready", s_ready, 0);
    chk("burst.done", s_done, 1);
    chk("burst.sample_count", s_cnt, 4);
    chk("burst.err_count", s_err, 0);

    // start ignored in RUN, then async reset with a sample in flight
    s_start = 1; tick; s_start = 0;
    s_valid = 1; s_a = 1; s_b = 1; s_p = 0; repeat (3) tick;
    s_valid = 0; tick; tick;
    s_expect("three", 3, 3, 3, 1);
    s_start = 1; tick; s_start = 0; tick;
    s_expect("ignored", 3, 3, 3, 1);
    chk("ignored.busy", s_busy, 1);
    s_valid = 1; s_a = 200; s_b = 200; s_p = 0; tick;
    s_valid = 0;
    rst_n = 0;
    #2;
    s_expect("arst", 0, 0, 0, 0);
    chk("arst.busy", s_busy, 0);
    chk("arst.in_ready", s_ready, 0);
    chk("arst.done", s_done, 0);
    tick;
    rst_n = 1;
    tick; tick; tick;
    s_expect("post_rst", 0, 0, 0, 0);
    chk("post_rst.busy", s_busy, 0);
    s_start = 1; tick; s_start = 0;
    s_valid = 1; s_a = 4; s_b = 4; s_p = 20; tick;
    s_valid = 0; tick; tick;
    s_expect("after_rst", 1, 1, 4, 4);

    // randomized 10000-sample run
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sed = 0;
    acc = 0; cyc = 0; ready_gaps = 0;
    b_start = 1; tick; b_start = 0;
    while (acc < 10000 && cyc < 60000) begin
      b_valid = ($urandom_range(0, 3) != 0);
      b_a = 8'($urandom);
      b_b = 8'($urandom);
      ex16 = 16'(int'(b_a) * int'(b_b));
      case ($urandom_range(0, 2))
        0:       b_p = ex16;
        1:       b_p = 16'(int'(ex16) + int'($urandom_range(0, 40)) - 20);
        default: b_p = 16'($urandom);
      endcase
      if (!b_ready) ready_gaps++;
      if (b_valid && b_ready) begin
        acc++;
        d = int'(ex16) - int'(b_p);
        m_cnt++;
        if (d != 0) m_err++;
        m_sum += (d < 0) ? -d : d;
        if (((d < 0) ? -d : d) > m_max) m_max = (d < 0) ? -d : d;
        m_sed += d;
      end
      tick;
      cyc++;
    end
    b_valid = 0;
    chk("rand.accepted", acc, 10000);
    chk("rand.ready_gaps", ready_gaps, 0);
    cyc = 0;
    while (!b_done && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("rand.done", b_done, 1);
    chk("rand.sample_count", b_cnt, m_cnt);
    chk("rand.err_count", b_err, m_err);
    chk("rand.sum_ed_abs", b_sum, m_sum);
    chk("rand.max_ed", b_max, m_max);
`ifdef DADDA_ERR_MON_SIGNED_ED_EN
    sed40 = m_sed[39:0];
    chk("rand.sum_ed", b_sed, sed40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
